// File: rtl/div_unit_pkg.sv
// Shared constants, FSM state type and helpers for the multi-cycle divider.
package div_unit_pkg;

  // Architectural register width; the divider only supports this width.
  localparam int N_REG    = 32;
  // Number of restoring shift-subtract iterations per division.
  localparam int DIV_ITER = 32;

  // Reset assert level (active-low).
  localparam logic RST_ENABLE    = 1'b0;

  // Level constants for the start/ready handshake with EX.
  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;
  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;

  // Stall request levels toward the pipeline controller.
  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_t;

  // Two's complement negate when neg is set, pass through otherwise.
  function automatic logic [N_REG-1:0] cond_neg(input logic neg,
                                                input logic [N_REG-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
// The compare is done on W+1 bits so divisors with the top bit set are
// handled: the shifted remainder can exceed 2^W - 1 before subtraction.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] divisor,
  input  logic         bit_in,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] partial;
  logic [W:0] diff;

  // Trial subtraction; a clear borrow bit means the divisor fits.
  always_comb begin
    partial  = {rem, bit_in};
    diff     = partial - {1'b0, divisor};
    q_bit    = ~diff[W];
    rem_next = q_bit ? diff[W-1:0] : partial[W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit for the EX stage.
// Returns {remainder, quotient} for the HI/LO write path and requests a
// pipeline stall while busy. The final iteration and sign fix-up share one
// edge, so a normal division reports ready after the 33rd edge counted from
// the edge that accepts the start request.
// Optional build macro: DIV_BY_ZERO_FLAG_EN adds o_div_zero, which marks a
// result produced by a zero divisor.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = N_REG,  // only 32 is supported
  parameter int CNT_W  = 6       // 2**CNT_W must exceed DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_signed,
  input  logic [DATA_W-1:0]   i_opdata1,
  input  logic [DATA_W-1:0]   i_opdata2,
  input  logic                i_start,
  input  logic                i_annul,
  output logic [2*DATA_W-1:0] o_result,
  output logic                o_ready,
  output logic                o_stallreq
`ifdef DIV_BY_ZERO_FLAG_EN
  ,
  output logic                o_div_zero
`endif
);

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  // Dividend shifts out MSB-first; quotient bits shift in at the LSB, so
  // after the last iteration this register holds the unsigned quotient.
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] rem_q;
  logic              quo_neg_q;
  logic              rem_neg_q;

  logic [DATA_W-1:0] rem_next;
  logic              q_bit;

  logic              start_ok;
  assign start_ok = (i_start == DIV_START) && !i_annul;

  div_step #(.W(DATA_W)) u_step (
    .rem      (rem_q),
    .divisor  (divisor_q),
    .bit_in   (dividend_q[DATA_W-1]),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Stall request: busy states, or a start being accepted this cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned
    // (which would infer a latch).
    o_stallreq = NO_STOP;
    case (state)
      DIV_ON, DIV_BY_ZERO: o_stallreq = STOP;
      DIV_FREE:            if (start_ok) o_stallreq = STOP;
      default:             o_stallreq = NO_STOP;
    endcase
  end

  // Divider FSM with iteration datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RST_ENABLE) begin
      // NOTE: datapath registers are reset too, so a reset mid-operation
      // leaves no stale operands or partial results behind.
      state      <= DIV_FREE;
      cnt        <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      o_result   <= '0;
      o_ready    <= DIV_NOT_READY;
`ifdef DIV_BY_ZERO_FLAG_EN
      o_div_zero <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values that were current before the edge.
      case (state)
        DIV_FREE: begin
          o_ready  <= DIV_NOT_READY;
          o_result <= '0;
          cnt      <= '0;
          if (start_ok) begin
            dividend_q <= cond_neg(i_signed & i_opdata1[DATA_W-1], i_opdata1);
            divisor_q  <= cond_neg(i_signed & i_opdata2[DATA_W-1], i_opdata2);
            rem_q      <= '0;
            quo_neg_q  <= i_signed & (i_opdata1[DATA_W-1] ^ i_opdata2[DATA_W-1]);
            rem_neg_q  <= i_signed & i_opdata1[DATA_W-1];
            state      <= (i_opdata2 == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end

        DIV_BY_ZERO: begin
          o_result <= '0;
          o_ready  <= DIV_READY;
          state    <= DIV_END;
`ifdef DIV_BY_ZERO_FLAG_EN
          o_div_zero <= 1'b1;
`endif
        end

        DIV_ON: begin
          if (i_annul) begin
            state    <= DIV_FREE;
            o_ready  <= DIV_NOT_READY;
            o_result <= '0;
            cnt      <= '0;
          end else begin
            dividend_q <= {dividend_q[DATA_W-2:0], q_bit};
            rem_q      <= rem_next;
            cnt        <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DIV_ITER - 1)) begin
              // Last iteration: apply the sign fix-up to this step's outputs.
              o_result <= {cond_neg(rem_neg_q, rem_next),
                           cond_neg(quo_neg_q, {dividend_q[DATA_W-2:0], q_bit})};
              o_ready  <= DIV_READY;
              state    <= DIV_END;
            end
          end
        end

        DIV_END: begin
          if (i_start == DIV_STOP) begin
            state    <= DIV_FREE;
            o_ready  <= DIV_NOT_READY;
            o_result <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
            o_div_zero <= 1'b0;
`endif
          end
        end

        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a transaction-level reference model
// (plain integer division plus a cycle countdown) is compared against the DUT
// on every falling clock edge; directed and random divisions drive it.
// Build with DIV_BY_ZERO_FLAG_EN defined to also cover o_div_zero.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        sgn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic        div_zero;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  div_unit dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_signed   (sgn),
    .i_opdata1  (op1),
    .i_opdata2  (op2),
    .i_start    (start),
    .i_annul    (annul),
    .o_result   (result),
    .o_ready    (ready),
    .o_stallreq (stallreq)
`ifdef DIV_BY_ZERO_FLAG_EN
    ,
    .o_div_zero (div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic: truncating division,
  // remainder carries the dividend's sign, zero divisor yields zero.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: idle / busy with a countdown / done.
  typedef enum {M_IDLE, M_BUSY, M_DONE} m_phase_t;
  m_phase_t    m_phase;
  int          m_left;
  bit          m_byz;
  logic [63:0] m_pend;
  logic [63:0] m_res;
  logic        m_ready;
  logic        m_zero;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= M_IDLE;
      m_left  <= 0;
      m_byz   <= 1'b0;
      m_pend  <= '0;
      m_res   <= '0;
      m_ready <= 1'b0;
      m_zero  <= 1'b0;
    end else begin
      case (m_phase)
        M_IDLE: begin
          m_ready <= 1'b0;
          m_res   <= '0;
          if (start && !annul) begin
            m_phase <= M_BUSY;
            m_byz   <= (op2 == 32'd0);
            m_left  <= (op2 == 32'd0) ? 1 : 32;
            m_pend  <= ref_div(sgn, op1, op2);
          end
        end
        M_BUSY: begin
          if (annul && !m_byz) begin
            m_phase <= M_IDLE;
          end else if (m_left == 1) begin
            m_phase <= M_DONE;
            m_ready <= 1'b1;
            m_res   <= m_pend;
            m_zero  <= m_byz;
          end else begin
            m_left <= m_left - 1;
          end
        end
        default: begin
          if (!start) begin
            m_phase <= M_IDLE;
            m_ready <= 1'b0;
            m_res   <= '0;
            m_zero  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_ready",  {63'd0, ready}, {63'd0, m_ready});
      check("cyc_result", result, m_res);
      check("cyc_stall",  {63'd0, stallreq},
            {63'd0, (m_phase == M_BUSY) || (m_phase == M_IDLE && start && !annul)});
`ifdef DIV_BY_ZERO_FLAG_EN
      check("cyc_div_zero", {63'd0, div_zero}, {63'd0, m_zero});
`endif
    end
  end

  // One full division: start held until ready, one extra END cycle, then
  // start dropped for one cycle. Called at posedge+2.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input bit use_lit, input logic [63:0] lit);
    int edges;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 2 : 33;
    sgn   = s;
    op1   = a;
    op2   = b;
    start = 1'b1;
    #1 check("stall_at_start", {63'd0, stallreq}, 64'd1);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (scramble && edges == 5) begin
        op1 = $urandom;
        op2 = $urandom;
        sgn = 1'($urandom);
      end
    end while (!ready && edges < 60);
    check("latency", 64'(edges), 64'(exp_lat));
    check("end_result", result, ref_div(s, a, b));
    check("end_stall", {63'd0, stallreq}, 64'd0);
    if (use_lit) check("end_literal", result, lit);
`ifdef DIV_BY_ZERO_FLAG_EN
    check("end_div_zero", {63'd0, div_zero}, {63'd0, b == 32'd0});
`endif
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    check("freed_ready", {63'd0, ready}, 64'd0);
    check("freed_result", result, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst_n = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    sgn   = 1'b0;
    op1   = '0;
    op2   = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_ready",  {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stall",  {63'd0, stallreq}, 64'd0);

    // Pin the reference model with hand-computed values.
    check("model_100_7",   ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    check("model_m7_2",    ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("model_7_m2",    ref_div(1'b1, 32'd7, 32'hFFFF_FFFE), {32'h0000_0001, 32'hFFFF_FFFD});
    check("model_ovf",     ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
    check("model_u_max_1", ref_div(1'b0, 32'hFFFF_FFFF, 32'd1), {32'd0, 32'hFFFF_FFFF});
    check("model_by_zero", ref_div(1'b0, 32'd5, 32'd0), 64'd0);

    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    // Directed divisions.
    run_op(1'b0, 32'd100, 32'd7, 1'b0, 1'b1, {32'd2, 32'd14});
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, {32'd0, 32'h8000_0000});
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, {32'd0, 32'hFFFF_FFFF});
    run_op(1'b0, 32'd5, 32'd0, 1'b0, 1'b1, 64'd0);
    // Back-to-back after a one-cycle start drop, with operands scrambled mid-run.
    run_op(1'b0, 32'd9, 32'd3, 1'b1, 1'b1, {32'd0, 32'd3});
    run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 1'b0, 64'd0);

    // Annul after 10 iterations: back to idle, no result.
    sgn = 1'b0; op1 = 32'h1234_5678; op2 = 32'd3; start = 1'b1;
    repeat (11) @(posedge clk);
    #2 annul = 1'b1; start = 1'b0;
    @(posedge clk); #2 annul = 1'b0;
    check("annul_ready", {63'd0, ready}, 64'd0);
    check("annul_stall", {63'd0, stallreq}, 64'd0);
    repeat (3) @(posedge clk);
    #2;

    // Start together with annul in idle: nothing starts.
    start = 1'b1; annul = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("start_annul_stall", {63'd0, stallreq}, 64'd0);
    check("start_annul_ready", {63'd0, ready}, 64'd0);
    #1 start = 1'b0; annul = 1'b0;
    @(posedge clk); #2;

    // Reset mid-iteration: outputs return to reset values immediately.
    sgn = 1'b1; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (15) @(posedge clk);
    #2 start = 1'b0; rst_n = 1'b0;
    #1;
    check("midrst_ready",  {63'd0, ready}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_stall",  {63'd0, stallreq}, 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;

    // Random divisions, including zero, one, all-ones and most-negative cases.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      run_op(rs, ra, rb, 1'($urandom), 1'b0, 64'd0);
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
